detector_sequencia_param: RTL

Parametrised serial pattern detector. It replaces fixed hard-coded serial-bit FSMs with one block that takes a runtime-loadable N-bit pattern, supports overlapping and non-overlapping match modes, and counts matches.
It sits on a 1-bit serial input stream sampled on a qualifying enable. It emits a registered one-cycle match pulse, a saturating match count and the current FSM fill state for debug.

---
 rtl/detector_sequencia_param.sv | 90 +++++++++
 1 files changed

// File: rtl/detector_sequencia_param.sv
// rtl/detector_sequencia_param.sv - runtime-loadable serial pattern detector
// Shift history plus a fill level; matches only once N valid bits are held.
module detector_sequencia_param #(
  parameter int                          LARGURA_PADRAO = 4,
  parameter int                          LARGURA_CONT   = 8,
  parameter logic [LARGURA_PADRAO-1:0]   PADRAO_RESET   = 4'b1011
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic                                   entrada,
  input  logic                                   carregar,
  input  logic [LARGURA_PADRAO-1:0]              padrao_in,
  input  logic                                   sobrepor,
  input  logic                                   limpar_cont,
  output logic                                   saida,
  output logic [LARGURA_CONT-1:0]                contagem,
  output logic                                   saturado,
  output logic [$clog2(LARGURA_PADRAO+1)-1:0]    saida_estado
);

  localparam int                  LE         = $clog2(LARGURA_PADRAO + 1);
  localparam logic [LE-1:0]       FILL_CHEIO = LE'(LARGURA_PADRAO);
  localparam logic [LARGURA_CONT-1:0] CONT_MAX = '1;

  logic [LARGURA_PADRAO-1:0] padrao_q, padrao_d;
  logic [LARGURA_PADRAO-1:0] hist_q, hist_d;
  logic [LE-1:0]             fill_q, fill_d;
  logic                      saida_q, saida_d;
  logic [LARGURA_CONT-1:0]   contagem_q, contagem_d;

  logic [LARGURA_PADRAO-1:0] cand;
  logic [LE-1:0]             fill_n;
  logic                      casamento;

  always_comb begin
    cand       = {hist_q[LARGURA_PADRAO-2:0], entrada};
    fill_n     = (fill_q == FILL_CHEIO) ? FILL_CHEIO : fill_q + LE'(1);
    // A zero history that happens to equal the pattern must not match early.
    casamento  = en && !carregar && (fill_n == FILL_CHEIO) && (cand == padrao_q);

    padrao_d   = padrao_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    saida_d    = 1'b0;
    contagem_d = contagem_q;

    if (carregar) begin
      padrao_d = padrao_in;
      hist_d   = '0;
      fill_d   = '0;
    end else if (en) begin
      hist_d  = cand;
      saida_d = casamento;
      if (casamento) begin
        fill_d = sobrepor ? FILL_CHEIO : '0;
      end else begin
        fill_d = fill_n;
      end
    end

    if (limpar_cont) begin
      contagem_d = '0;
    end else if (casamento && (contagem_q != CONT_MAX)) begin
      contagem_d = contagem_q + LARGURA_CONT'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      padrao_q   <= PADRAO_RESET;
      hist_q     <= '0;
      fill_q     <= '0;
      saida_q    <= 1'b0;
      contagem_q <= '0;
    end else begin
      padrao_q   <= padrao_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      saida_q    <= saida_d;
      contagem_q <= contagem_d;
    end
  end

  assign saida        = saida_q;
  assign contagem     = contagem_q;
  assign saturado     = &contagem_q;
  assign saida_estado = fill_q;

endmodule
